// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM controller: FSM state encoding,
// SRAM pad widths and the default CPU base address of SRAM word 0.
package sram_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOW  = 3'd1,
    HIGH = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

endpackage

// File: rtl/sram_ctrl.sv
// SRAM controller: turns one 32-bit CPU load/store into two 16-bit SRAM
// half-word accesses (low half first), followed by WAIT_CYCLES idle bus
// cycles and one DONE cycle in which ready releases the pipeline.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int         WORD_W    = SRAM_AW - 1;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t                    state;
  state_t                    state_next;
  logic [3:0]                cnt;
  logic                      op_write;
  logic [WORD_W-1:0]         word;
  logic [SRAM_DW-1:0]        data_hi;
  logic [WORD_W-1:0]         word_next;

  // Word index relative to the SRAM base; the subtraction wraps modulo 2^32
  // and only the bits that reach the SRAM half-word address are kept.
  assign word_next = WORD_W'((address - BASE_ADDR) >> 2);

  // The pipeline may only advance when no request is pending or an access
  // has just finished.
  assign ready = (state == DONE) || ((state == IDLE) && !wr_en && !rd_en);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; DONE always returns to IDLE so back-to-back requests
  // are separated by one IDLE cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (wr_en || rd_en) begin
          state_next = LOW;
        end else begin
          state_next = IDLE;
        end
      end
      LOW:  state_next = HIGH;
      HIGH: state_next = WAIT;
      WAIT: begin
        if (cnt == WAIT_LAST) begin
          state_next = DONE;
        end else begin
          state_next = WAIT;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, registered SRAM pad drive, wait counter and read capture.
  // Pad outputs are loaded one edge ahead so they are valid for the whole
  // LOW / HIGH cycle they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= 4'd0;
      op_write    <= 1'b0;
      word        <= '0;
      data_hi     <= '0;
      read_data   <= 32'd0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en || rd_en) begin
            op_write  <= wr_en;
            word      <= word_next;
            data_hi   <= write_data[31:16];
            sram_addr <= {word_next, 1'b0};
            if (wr_en) begin
              sram_dq_out <= write_data[15:0];
              sram_we_n   <= 1'b0;
              sram_dq_oe  <= 1'b1;
            end
          end
        end
        LOW: begin
          sram_addr <= {word, 1'b1};
          if (op_write) begin
            sram_dq_out <= data_hi;
          end else begin
            read_data[15:0] <= sram_dq_in;
          end
        end
        HIGH: begin
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          cnt        <= 4'd0;
          if (!op_write) begin
            read_data[31:16] <= sram_dq_in;
          end
        end
        WAIT: begin
          if (cnt != WAIT_LAST) begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: a directed table, hand sequences for
// held requests and mid-access reset, and randomized accesses checked
// against a word-level memory model.
module tb_sram_ctrl;

  localparam int W = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  int checks;
  int errors;
  int oe_bad;

  // SRAM pad model: half-words that were never written read back a fixed
  // address-derived pattern.
  logic [15:0] mem [logic [17:0]];
  // CPU-level reference for the randomized region: 32-bit word per index.
  logic [31:0] ref_mem [logic [16:0]];

  sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] init_half(input logic [17:0] a);
    return 16'(a * 18'd37) ^ 16'h5AC3;
  endfunction

  function automatic logic [15:0] peek(input logic [17:0] a);
    if (mem.exists(a)) return mem[a];
    return init_half(a);
  endfunction

  function automatic logic [31:0] ref_get(input logic [16:0] w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return {init_half({w, 1'b1}), init_half({w, 1'b0})};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance past a rising edge and present the SRAM read data for the
  // address now on the pads.
  task automatic tick();
    @(posedge clk);
    #1;
    sram_dq_in = peek(sram_addr);
  endtask

  // Move to the falling edge; commit a pad write if the strobe is active.
  task automatic settle();
    @(negedge clk);
    if (!sram_we_n) mem[sram_addr] = sram_dq_out;
    if (sram_dq_oe == sram_we_n) oe_bad++;
  endtask

  // One complete access, with expectations derived from the request alone.
  task automatic run_access(input string tag, input logic wr, input logic rd,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int chg, input logic [17:0] exp_lo,
                            input logic [17:0] exp_hi, input logic [31:0] exp_rd);
    int rdy_cyc;
    int we_cnt;
    logic [17:0] a_lo;
    logic [17:0] a_hi;
    logic [15:0] d_lo;
    logic [15:0] d_hi;
    logic [31:0] rdata;
    rdy_cyc = -1; we_cnt = 0; a_lo = '0; a_hi = '0; d_lo = '0; d_hi = '0; rdata = '0;
    tick();
    wr_en = wr; rd_en = rd; address = addr; write_data = wd;
    settle();
    chk({tag, ".req_ready"}, 32'(ready), 32'd0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == chg) begin
        address = 32'd2000;
        write_data = ~wd;
      end
      settle();
      if (k == 1) a_lo = sram_addr;
      if (k == 2) a_hi = sram_addr;
      if (!sram_we_n) begin
        we_cnt++;
        if (k == 1) d_lo = sram_dq_out;
        if (k == 2) d_hi = sram_dq_out;
      end
      if (ready) begin
        rdy_cyc = k;
        rdata = read_data;
        break;
      end
    end
    chk({tag, ".ready_cycle"}, 32'(rdy_cyc), 32'(3 + W));
    chk({tag, ".addr_lo"}, 32'(a_lo), 32'(exp_lo));
    chk({tag, ".addr_hi"}, 32'(a_hi), 32'(exp_hi));
    chk({tag, ".we_cycles"}, 32'(we_cnt), wr ? 32'd2 : 32'd0);
    if (wr) begin
      chk({tag, ".dq_lo"}, 32'(d_lo), 32'(wd[15:0]));
      chk({tag, ".dq_hi"}, 32'(d_hi), 32'(wd[31:16]));
    end
    chk({tag, ".read_data"}, rdata, exp_rd);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    settle();
    chk({tag, ".idle_ready"}, 32'(ready), 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wd;
    int          chg;
    logic        pre;
    logic [15:0] plo;
    logic [15:0] phi;
    logic [17:0] exp_lo;
    logic [17:0] exp_hi;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [31:0] last_rd;
    logic [31:0] rdy_mask;
    logic [31:0] we_mask;
    logic [31:0] exp_rdy_mask;
    logic [31:0] exp_we_mask;
    logic [16:0] w;
    int          we_cnt;
    checks = 0; errors = 0; oe_bad = 0;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    address = 32'd0; write_data = 32'd0; sram_dq_in = 16'd0;

    vecs[0]  = '{1'b1, 1'b0, 32'd1028,   32'hDEADBEEF, 0, 1'b0, 16'h0, 16'h0, 18'd2, 18'd3, 32'h00000000};
    vecs[1]  = '{1'b0, 1'b1, 32'd1028,   32'h0,        0, 1'b1, 16'h1234, 16'h5678, 18'd2, 18'd3, 32'h56781234};
    vecs[2]  = '{1'b1, 1'b1, 32'd1028,   32'hCAFEF00D, 0, 1'b0, 16'h0, 16'h0, 18'd2, 18'd3, 32'h56781234};
    vecs[3]  = '{1'b0, 1'b1, 32'd1031,   32'h0,        0, 1'b0, 16'h0, 16'h0, 18'd2, 18'd3, 32'hCAFEF00D};
    vecs[4]  = '{1'b1, 1'b0, 32'd1024,   32'h11112222, 0, 1'b0, 16'h0, 16'h0, 18'd0, 18'd1, 32'hCAFEF00D};
    vecs[5]  = '{1'b1, 1'b0, 32'd525312, 32'h33334444, 0, 1'b0, 16'h0, 16'h0, 18'd0, 18'd1, 32'hCAFEF00D};
    vecs[6]  = '{1'b0, 1'b1, 32'd1024,   32'h0,        0, 1'b0, 16'h0, 16'h0, 18'd0, 18'd1, 32'h33334444};
    vecs[7]  = '{1'b1, 1'b0, 32'd1020,   32'hA5A55A5A, 0, 1'b0, 16'h0, 16'h0, 18'h3FFFE, 18'h3FFFF, 32'h33334444};
    vecs[8]  = '{1'b0, 1'b1, 32'd1020,   32'h0,        0, 1'b0, 16'h0, 16'h0, 18'h3FFFE, 18'h3FFFF, 32'hA5A55A5A};
    vecs[9]  = '{1'b1, 1'b0, 32'd1036,   32'h0BADC0DE, 1, 1'b0, 16'h0, 16'h0, 18'd6, 18'd7, 32'hA5A55A5A};
    vecs[10] = '{1'b0, 1'b1, 32'd1036,   32'h0,        3, 1'b0, 16'h0, 16'h0, 18'd6, 18'd7, 32'h0BADC0DE};
    vecs[11] = '{1'b1, 1'b0, 32'd1040,   32'h01234567, 4, 1'b0, 16'h0, 16'h0, 18'd8, 18'd9, 32'h0BADC0DE};
    vecs[12] = '{1'b0, 1'b1, 32'd1040,   32'h0,        0, 1'b0, 16'h0, 16'h0, 18'd8, 18'd9, 32'h01234567};

    // Reset state.
    tick();
    settle();
    chk("rst.read_data", read_data, 32'd0);
    chk("rst.sram_addr", 32'(sram_addr), 32'd0);
    chk("rst.dq_out", 32'(sram_dq_out), 32'd0);
    chk("rst.we_n", 32'(sram_we_n), 32'd1);
    chk("rst.dq_oe", 32'(sram_dq_oe), 32'd0);
    rst = 1'b0;
    tick();
    settle();
    chk("rst.idle_ready", 32'(ready), 32'd1);

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].pre) begin
        mem[vecs[i].exp_lo] = vecs[i].plo;
        mem[vecs[i].exp_hi] = vecs[i].phi;
      end
      run_access($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd, vecs[i].addr,
                 vecs[i].wd, vecs[i].chg, vecs[i].exp_lo, vecs[i].exp_hi, vecs[i].exp_rd);
    end
    chk("vec.word2000_untouched", 32'(mem.exists(18'd488)), 32'd0);

    // Request held through DONE: one ready per access, one IDLE between.
    rdy_mask = '0; we_mask = '0;
    exp_rdy_mask = (32'd1 << (3 + W)) | (32'd1 << (7 + 2 * W));
    exp_we_mask  = (32'd1 << 1) | (32'd1 << 2) | (32'd1 << (5 + W)) | (32'd1 << (6 + W));
    tick();
    wr_en = 1'b1; address = 32'd1044; write_data = 32'h5555AAAA;
    settle();
    rdy_mask[0] = ready;
    we_mask[0] = ~sram_we_n;
    for (int k = 1; k <= 7 + 2 * W; k++) begin
      tick();
      settle();
      rdy_mask[k] = ready;
      we_mask[k] = ~sram_we_n;
    end
    chk("hold.ready_pulses", rdy_mask, exp_rdy_mask);
    chk("hold.we_cycles", we_mask, exp_we_mask);
    tick();
    wr_en = 1'b0;
    settle();
    chk("hold.idle_ready", 32'(ready), 32'd1);

    // Reset asserted in HIGH of a write aborts it.
    tick();
    wr_en = 1'b1; address = 32'd1048; write_data = 32'h77778888;
    settle();
    tick();
    settle();
    tick();
    settle();
    chk("abort.we_in_high", 32'(sram_we_n), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("abort.we_n", 32'(sram_we_n), 32'd1);
    chk("abort.dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("abort.read_data", read_data, 32'd0);
    chk("abort.sram_addr", 32'(sram_addr), 32'd0);
    wr_en = 1'b0;
    tick();
    rst = 1'b0;
    settle();
    chk("abort.idle_ready", 32'(ready), 32'd1);
    we_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      settle();
      if (!sram_we_n) we_cnt++;
    end
    chk("abort.no_strobe", 32'(we_cnt), 32'd0);

    // Randomized accesses against the word-level reference.
    last_rd = 32'd0;
    for (int n = 0; n < 40; n++) begin
      int op;
      int gap;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      op = $urandom_range(0, 2);
      gap = $urandom_range(0, 2);
      w = 17'(1024 + $urandom_range(0, 255));
      addr = BASE + 32'(w) * 32'd4 + 32'($urandom_range(0, 3));
      wd = $urandom;
      for (int g = 0; g < gap; g++) begin
        tick();
        settle();
      end
      if (op == 1) begin
        exp_rd = ref_get(w);
        last_rd = exp_rd;
      end else begin
        exp_rd = last_rd;
        ref_mem[w] = wd;
      end
      run_access($sformatf("rnd%0d", n), op != 1, op != 0, addr, wd,
                 $urandom_range(0, 6), {w, 1'b0}, {w, 1'b1}, exp_rd);
    end

    chk("oe_tracks_we", 32'(oe_bad), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: idle bus cycles after the second half-word access (range 1..15).
REQ-002 SHALL have parameter BASE_ADDR, default 32'd1024: CPU byte address mapped to SRAM word 0.
REQ-003 SHALL have one clock; reset is asynchronous and active-high. Ports: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset.
REQ-004 SHALL have the port wr_en in 1: MEM-stage store request.
REQ-005 SHALL have the port rd_en in 1: MEM-stage load request.
REQ-006 SHALL have the port address in 32: CPU byte address.
REQ-007 SHALL have the port write_data in 32: store data.
REQ-008 SHALL have the port read_data out 32: load result.
REQ-009 SHALL have the port ready out 1: low means freeze the pipeline.
REQ-010 SHALL have the port sram_addr out 18: SRAM half-word address.
REQ-011 SHALL have the port sram_dq_out out 16: write data to the SRAM pad.
REQ-012 SHALL have the port sram_dq_in in 16: read data from the SRAM pad.
REQ-013 SHALL have the port sram_dq_oe out 1: pad output enable.
REQ-014 SHALL have the port sram_we_n out 1: active-low SRAM write strobe.

Function
REQ-015 SHALL use states IDLE, LOW, HIGH, WAIT, DONE.
REQ-016 IDLE SHALL move to LOW on the next edge when wr_en or rd_en is 1; otherwise it SHALL stay in IDLE.
REQ-017 LOW SHALL move to HIGH, HIGH SHALL move to WAIT, and DONE SHALL move to IDLE, each unconditionally.
REQ-018 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit counter loaded to 0 on HIGH->WAIT, then move to DONE.
REQ-019 On leaving IDLE, SHALL latch op (write if wr_en, else read), word = (address - BASE_ADDR) >> 2 using modulo-2^32 arithmetic, and write_data.
REQ-020 SHALL keep the latched values for the whole access; input changes during LOW..DONE SHALL be ignored.
REQ-021 When wr_en and rd_en are both 1, write SHALL win.
REQ-022 sram_addr SHALL be {word[16:0],1'b0} in LOW, {word[16:0],1'b1} in HIGH, and hold its last value elsewhere.
REQ-023 For a write, sram_dq_out SHALL be data[15:0] in LOW and data[31:16] in HIGH, with sram_we_n=0 and sram_dq_oe=1 in those states only.
REQ-024 In all other states, sram_we_n SHALL be 1 and sram_dq_oe SHALL be 0.
REQ-025 For a read, SHALL register sram_dq_in into read_data[15:0] at the end of LOW and into read_data[31:16] at the end of HIGH.
REQ-026 read_data SHALL hold until the next read overwrites it; writes SHALL NOT alter it.
REQ-027 ready SHALL be combinational: 1 in DONE; 1 in IDLE when wr_en=rd_en=0; 0 otherwise, including the IDLE request cycle.
REQ-028 Latency: request visible in cycle 0 gives ready=1 in cycle 3+WAIT_CYCLES, i.e. exactly one ready cycle per access.
REQ-029 A request still asserted in DONE SHALL NOT start a new access from DONE; the new access SHALL begin from IDLE on the following cycle.
REQ-030 Back-to-back accesses SHALL be separated by exactly one IDLE cycle.

Reset
REQ-031 rst SHALL asynchronously force state=IDLE, counter=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, and latched op/word/data=0.
REQ-032 rst asserted mid-access SHALL abort it with no further SRAM write strobe.
REQ-033 After rst deasserts, ready SHALL follow REQ-027 from IDLE.

Structure
REQ-034 Package sram_pkg SHALL hold the state enum, SRAM_AW=18, SRAM_DW=16, and the BASE_ADDR default.
REQ-035 No sub-module SHALL be used; FSM, counter and datapath SHALL stay in one module.

Verification
REQ-036 Write: address=1028, write_data=32'hDEADBEEF, WAIT_CYCLES=2 -> sram_addr 2 with dq BEEF, then 3 with dq DEAD, we_n low 2 cycles, ready=1 only in cycle 5.
REQ-037 Read: address=1028, SRAM returns 16'h1234 then 16'h5678 -> read_data=32'h56781234 in DONE, ready low cycles 0-4.
REQ-038 Simultaneous wr_en=rd_en=1 -> write sequence executes, read_data unchanged.
REQ-039 Request held high through DONE -> exactly one IDLE cycle, then a second identical access, with ready pulsing once per access.
REQ-040 rst asserted in HIGH of a write -> next cycle IDLE, we_n=1, dq_oe=0, read_data=0.
REQ-041 Inputs changed in WAIT (address=2000) -> completed access uses the original word.
